// File: rtl/swc_pkg.sv
// Shared types and width helpers for the stream width converter.
package swc_pkg;

    typedef enum logic [0:0] {
        ACCUM,
        DRAIN
    } swc_state_e;

    // Fill counter must count 0..N+M inclusive.
    function automatic int unsigned swc_fill_w(input int unsigned n, input int unsigned m);
        return $clog2(n + m + 1);
    endfunction

    // out_bits_o must represent 0..M inclusive.
    function automatic int unsigned swc_ob_w(input int unsigned m);
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/swc_bitbuf.sv
// Left-justified bit buffer: pop removes the top M bits, push appends N bits below the fill.
module swc_bitbuf
    import swc_pkg::*;
#(
    parameter int unsigned N = 8,
    parameter int unsigned M = 32
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        push,
    input  logic                        pop,
    input  logic [N-1:0]                din,
    output logic [M-1:0]                word,
    output logic [swc_fill_w(N, M)-1:0] fill
);

    localparam int unsigned BUF_W  = N + M;
    localparam int unsigned FILL_W = swc_fill_w(N, M);
    localparam logic [FILL_W-1:0] M_F = FILL_W'(M);
    localparam logic [FILL_W-1:0] N_F = FILL_W'(N);

    logic [BUF_W-1:0]  bits_q, bits_d, bits_pop;
    logic [FILL_W-1:0] fill_q, fill_d, fill_pop;
    logic [BUF_W-1:0]  din_ext;

    assign din_ext = {{M{1'b0}}, din};

    // Pop first, then insert the new beat just below the post-pop fill level.
    always_comb begin
        bits_pop = bits_q;
        fill_pop = fill_q;
        if (pop) begin
            bits_pop = bits_q << M;
            fill_pop = (fill_q >= M_F) ? fill_q - M_F : '0;
        end
        bits_d = bits_pop;
        fill_d = fill_pop;
        // Push is only granted with fill <= M, so the shift M - fill is never negative.
        if (push) begin
            bits_d = bits_pop | (din_ext << (M_F - fill_pop));
            fill_d = fill_pop + N_F;
        end
    end

    // Buffer and fill registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bits_q <= '0;
            fill_q <= '0;
        end else begin
            bits_q <= bits_d;
            fill_q <= fill_d;
        end
    end

    assign word = bits_q[BUF_W-1 -: M];
    assign fill = fill_q;

endmodule

// File: rtl/stream_width_conv.sv
// Valid/ready width converter, N-bit beats in, M-bit words out, MSB-first, last-framed.
module stream_width_conv
    import swc_pkg::*;
#(
    parameter int unsigned N = 8,
    parameter int unsigned M = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   vld_i,
    input  logic [N-1:0]           din,
    input  logic                   last_i,
    output logic                   rdy_o,
    output logic                   vld_o,
    output logic [M-1:0]           dout,
    output logic [swc_ob_w(M)-1:0] out_bits_o,
    output logic                   last_o,
    input  logic                   rdy_i
);

    localparam int unsigned FILL_W = swc_fill_w(N, M);
    localparam int unsigned OB_W   = swc_ob_w(M);
    localparam logic [FILL_W-1:0] M_F = FILL_W'(M);

    swc_state_e        state_q, state_d;
    logic              accept_en_q;
    logic              push, pop;
    logic [FILL_W-1:0] fill;

    assign push = vld_i & rdy_o;
    assign pop  = vld_o & rdy_i;

    // Handshake outputs derive from registers only, no combinational rdy_i -> rdy_o path.
    assign rdy_o  = accept_en_q && (state_q == ACCUM) && (fill <= M_F);
    assign vld_o  = (fill >= M_F) || ((state_q == DRAIN) && (fill != '0));
    assign last_o = (state_q == DRAIN) && (fill <= M_F) && (fill != '0);
    assign out_bits_o = (fill >= M_F) ? OB_W'(M) : OB_W'(fill);

    // Frame FSM next state: enter DRAIN on an accepted last beat, leave when emptied.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ACCUM:   if (push && last_i) state_d = DRAIN;
            DRAIN:   if (pop && (fill <= M_F)) state_d = ACCUM;
            default: state_d = ACCUM;
        endcase
    end

    // State register; accept_en_q holds rdy_o low until the first edge after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ACCUM;
            accept_en_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            accept_en_q <= 1'b1;
        end
    end

    swc_bitbuf #(
        .N (N),
        .M (M)
    ) u_bitbuf (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .din   (din),
        .word  (dout),
        .fill  (fill)
    );

endmodule

// File: tb/tb_stream_width_conv.sv
// Directed bench for three converter configurations with per-instance expected-word queues.
module tb_stream_width_conv;

    typedef struct {
        logic [31:0] data;
        logic [7:0]  bits;
        logic        last;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Instance A: 8 -> 32
    logic a_vld_i = 0, a_last_i = 0, a_rdy_i = 0;
    logic [7:0]  a_din = '0;
    logic a_rdy_o, a_vld_o, a_last_o;
    logic [31:0] a_dout;
    logic [5:0]  a_ob;
    // Instance B: 32 -> 8
    logic b_vld_i = 0, b_last_i = 0, b_rdy_i = 0;
    logic [31:0] b_din = '0;
    logic b_rdy_o, b_vld_o, b_last_o;
    logic [7:0]  b_dout;
    logic [3:0]  b_ob;
    // Instance C: 12 -> 8
    logic c_vld_i = 0, c_last_i = 0, c_rdy_i = 0;
    logic [11:0] c_din = '0;
    logic c_rdy_o, c_vld_o, c_last_o;
    logic [7:0]  c_dout;
    logic [3:0]  c_ob;

    exp_t qa[$];
    exp_t qb[$];
    exp_t qc[$];
    exp_t ea, eb, ec;

    stream_width_conv #(.N(8), .M(32)) u_a (
        .clk(clk), .rst_n(rst_n), .vld_i(a_vld_i), .din(a_din), .last_i(a_last_i),
        .rdy_o(a_rdy_o), .vld_o(a_vld_o), .dout(a_dout), .out_bits_o(a_ob),
        .last_o(a_last_o), .rdy_i(a_rdy_i)
    );
    stream_width_conv #(.N(32), .M(8)) u_b (
        .clk(clk), .rst_n(rst_n), .vld_i(b_vld_i), .din(b_din), .last_i(b_last_i),
        .rdy_o(b_rdy_o), .vld_o(b_vld_o), .dout(b_dout), .out_bits_o(b_ob),
        .last_o(b_last_o), .rdy_i(b_rdy_i)
    );
    stream_width_conv #(.N(12), .M(8)) u_c (
        .clk(clk), .rst_n(rst_n), .vld_i(c_vld_i), .din(c_din), .last_i(c_last_i),
        .rdy_o(c_rdy_o), .vld_o(c_vld_o), .dout(c_dout), .out_bits_o(c_ob),
        .last_o(c_last_o), .rdy_i(c_rdy_i)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk(input logic [31:0] d, input logic [7:0] b, input logic l);
        exp_t e;
        e.data = d;
        e.bits = b;
        e.last = l;
        return e;
    endfunction

    // Scoreboards: compare at the negedge before each pop edge.
    always @(negedge clk) begin
        if (rst_n && a_vld_o && a_rdy_i) begin
            if (qa.size() == 0) check("a_unexpected_word", {32'd0, a_dout}, 64'hdead);
            else begin
                ea = qa.pop_front();
                check("a_dout", {32'd0, a_dout}, {32'd0, ea.data});
                check("a_out_bits", {58'd0, a_ob}, {56'd0, ea.bits});
                check("a_last", {63'd0, a_last_o}, {63'd0, ea.last});
            end
        end
        if (rst_n && b_vld_o && b_rdy_i) begin
            if (qb.size() == 0) check("b_unexpected_word", {56'd0, b_dout}, 64'hdead);
            else begin
                eb = qb.pop_front();
                check("b_dout", {56'd0, b_dout}, {32'd0, eb.data});
                check("b_out_bits", {60'd0, b_ob}, {56'd0, eb.bits});
                check("b_last", {63'd0, b_last_o}, {63'd0, eb.last});
            end
        end
        if (rst_n && c_vld_o && c_rdy_i) begin
            if (qc.size() == 0) check("c_unexpected_word", {56'd0, c_dout}, 64'hdead);
            else begin
                ec = qc.pop_front();
                check("c_dout", {56'd0, c_dout}, {32'd0, ec.data});
                check("c_out_bits", {60'd0, c_ob}, {56'd0, ec.bits});
                check("c_last", {63'd0, c_last_o}, {63'd0, ec.last});
            end
        end
    end

    // Each push task starts and ends at posedge+1 so calls chain back-to-back.
    task automatic push_a(input logic [7:0] d, input logic l);
        int t = 0;
        a_vld_i = 1'b1; a_din = d; a_last_i = l;
        @(negedge clk);
        while (!a_rdy_o && t < 50) begin @(negedge clk); t++; end
        if (!a_rdy_o) check("a_push_timeout", 64'd0, 64'd1);
        @(posedge clk); #1;
        a_vld_i = 1'b0; a_last_i = 1'b0;
    endtask

    task automatic push_b(input logic [31:0] d, input logic l);
        int t = 0;
        b_vld_i = 1'b1; b_din = d; b_last_i = l;
        @(negedge clk);
        while (!b_rdy_o && t < 50) begin @(negedge clk); t++; end
        if (!b_rdy_o) check("b_push_timeout", 64'd0, 64'd1);
        @(posedge clk); #1;
        b_vld_i = 1'b0; b_last_i = 1'b0;
    endtask

    task automatic push_c(input logic [11:0] d, input logic l);
        int t = 0;
        c_vld_i = 1'b1; c_din = d; c_last_i = l;
        @(negedge clk);
        while (!c_rdy_o && t < 50) begin @(negedge clk); t++; end
        if (!c_rdy_o) check("c_push_timeout", 64'd0, 64'd1);
        @(posedge clk); #1;
        c_vld_i = 1'b0; c_last_i = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    initial begin
        int c0;
        // Reset values while held in reset
        #3;
        check("rst_a_vld", {63'd0, a_vld_o}, 64'd0);
        check("rst_a_dout", {32'd0, a_dout}, 64'd0);
        check("rst_a_ob", {58'd0, a_ob}, 64'd0);
        check("rst_a_last", {63'd0, a_last_o}, 64'd0);
        check("rst_b_vld", {63'd0, b_vld_o}, 64'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_a_rdy_before_edge", {63'd0, a_rdy_o}, 64'd0);
        check("rst_c_rdy_before_edge", {63'd0, c_rdy_o}, 64'd0);
        @(posedge clk); #1;
        check("rst_a_rdy_after_edge", {63'd0, a_rdy_o}, 64'd1);
        check("rst_b_rdy_after_edge", {63'd0, b_rdy_o}, 64'd1);
        check("rst_c_rdy_after_edge", {63'd0, c_rdy_o}, 64'd1);

        // 1. 8->32 back-to-back pack
        a_rdy_i = 1'b1; b_rdy_i = 1'b1; c_rdy_i = 1'b1;
        qa.push_back(mk(32'h11223344, 8'd32, 1'b0));
        c0 = cyc;
        push_a(8'h11, 1'b0); push_a(8'h22, 1'b0); push_a(8'h33, 1'b0); push_a(8'h44, 1'b0);
        check("t1_no_bubble_cycles", 64'(cyc - c0), 64'd4);
        check("t1_vld_after_4th", {63'd0, a_vld_o}, 64'd1);
        check("t1_dout", {32'd0, a_dout}, 64'h11223344);
        idle(2);
        check("t1_vld_after_pop", {63'd0, a_vld_o}, 64'd0);

        // 2. 32->8 unpack on consecutive cycles
        qb.push_back(mk(32'hAA, 8'd8, 1'b0));
        qb.push_back(mk(32'hBB, 8'd8, 1'b0));
        qb.push_back(mk(32'hCC, 8'd8, 1'b0));
        qb.push_back(mk(32'hDD, 8'd8, 1'b0));
        push_b(32'hAABBCCDD, 1'b0);
        for (int k = 0; k < 4; k++) begin
            check("t2_vld_consecutive", {63'd0, b_vld_o}, 64'd1);
            check("t2_rdy_until_fill_le_m", {63'd0, b_rdy_o}, (k == 3) ? 64'd1 : 64'd0);
            idle(1);
        end
        check("t2_vld_empty", {63'd0, b_vld_o}, 64'd0);

        // 3. 12->8 non-integer ratio
        qc.push_back(mk(32'hAB, 8'd8, 1'b0));
        qc.push_back(mk(32'hCD, 8'd8, 1'b0));
        qc.push_back(mk(32'hEF, 8'd8, 1'b0));
        push_c(12'hABC, 1'b0);
        push_c(12'hDEF, 1'b0);
        idle(4);
        check("t3_vld_empty", {63'd0, c_vld_o}, 64'd0);
        check("t3_rdy_empty", {63'd0, c_rdy_o}, 64'd1);

        // 4. last flush of partial word
        qa.push_back(mk(32'h11223300, 8'd24, 1'b1));
        push_a(8'h11, 1'b0); push_a(8'h22, 1'b0); push_a(8'h33, 1'b1);
        check("t4_vld", {63'd0, a_vld_o}, 64'd1);
        check("t4_last", {63'd0, a_last_o}, 64'd1);
        check("t4_ob", {58'd0, a_ob}, 64'd24);
        check("t4_rdy_in_drain", {63'd0, a_rdy_o}, 64'd0);
        idle(1);
        check("t4_rdy_after_pop", {63'd0, a_rdy_o}, 64'd1);
        check("t4_vld_after_pop", {63'd0, a_vld_o}, 64'd0);
        check("t4_last_after_pop", {63'd0, a_last_o}, 64'd0);

        // 5. backpressure for six cycles
        a_rdy_i = 1'b0;
        qa.push_back(mk(32'h01020304, 8'd32, 1'b0));
        qa.push_back(mk(32'h05060708, 8'd32, 1'b0));
        push_a(8'h01, 1'b0); push_a(8'h02, 1'b0); push_a(8'h03, 1'b0); push_a(8'h04, 1'b0);
        check("t5_rdy_at_fill_m", {63'd0, a_rdy_o}, 64'd1);
        push_a(8'h05, 1'b0);
        check("t5_rdy_over_m", {63'd0, a_rdy_o}, 64'd0);
        check("t5_stall_dout", {32'd0, a_dout}, 64'h01020304);
        idle(1);
        check("t5_stall_dout_hold", {32'd0, a_dout}, 64'h01020304);
        check("t5_stall_ob_hold", {58'd0, a_ob}, 64'd32);
        check("t5_stall_last_hold", {63'd0, a_last_o}, 64'd0);
        a_rdy_i = 1'b1;
        push_a(8'h06, 1'b0); push_a(8'h07, 1'b0); push_a(8'h08, 1'b0);
        idle(3);

        // 6. async reset mid-frame, then a clean frame
        push_a(8'h11, 1'b0); push_a(8'h22, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check("t6_rst_dout", {32'd0, a_dout}, 64'd0);
        check("t6_rst_vld", {63'd0, a_vld_o}, 64'd0);
        check("t6_rst_ob", {58'd0, a_ob}, 64'd0);
        check("t6_rst_rdy", {63'd0, a_rdy_o}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        qa.push_back(mk(32'h55667788, 8'd32, 1'b0));
        push_a(8'h55, 1'b0); push_a(8'h66, 1'b0); push_a(8'h77, 1'b0); push_a(8'h88, 1'b0);
        idle(3);

        check("qa_drained", 64'(qa.size()), 64'd0);
        check("qb_drained", 64'(qb.size()), 64'd0);
        check("qc_drained", 64'(qc.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
